// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory access unit with 4-entry in-order tracking FIFO; optional feature macro MEM_RDATA_BYPASS_EN
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        IN_valid,
    input  logic        IN_isLoad,
    input  logic [31:0] IN_addr,
    input  logic [1:0]  IN_size,
    input  logic        IN_signExt,
    input  logic [31:0] IN_wdata,
    input  logic [3:0]  IN_wmask,
    input  logic        IN_exception,
    input  logic [5:0]  IN_tagDst,
    input  logic [4:0]  IN_nmDst,
    input  logic [5:0]  IN_sqN,
    output logic        OUT_stall,
    output logic        OUT_memReq,
    output logic        OUT_memWe,
    output logic [29:0] OUT_memAddr,
    output logic [31:0] OUT_memWdata,
    output logic [3:0]  OUT_memWmask,
    input  logic        IN_memAck,
    input  logic        IN_memRvalid,
    input  logic [31:0] IN_memRdata,
    output logic        OUT_resValid,
    output logic [31:0] OUT_resData,
    output logic [5:0]  OUT_resTagDst,
    output logic [4:0]  OUT_resNmDst,
    output logic [5:0]  OUT_resSqN,
    output logic        OUT_resException
);

    typedef enum logic {
        S_IDLE,
        S_WAIT_ACK
    } state_t;

    // Issue FSM and FIFO bookkeeping
    state_t      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;

    // Request register; req_idx_q is the issue pointer (FIFO slot owning the request)
    logic [29:0] req_addr_q;
    logic        req_we_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_wmask_q;
    logic [1:0]  req_idx_q;

    // Tracking FIFO entries
    logic [3:0]  ent_load_q;
    logic [3:0]  ent_sext_q;
    logic [3:0]  ent_exc_q;
    logic [3:0]  ent_acked_q;
    logic [3:0]  ent_done_q;
    logic [1:0]  ent_off_q  [4];
    logic [1:0]  ent_size_q [4];
    logic [5:0]  ent_tag_q  [4];
    logic [4:0]  ent_nm_q   [4];
    logic [5:0]  ent_sqn_q  [4];
    logic [31:0] ent_data_q [4];

    // Registered result
    logic        res_valid_q;
    logic [31:0] res_data_q, res_data_d;
    logic [5:0]  res_tag_q;
    logic [4:0]  res_nm_q;
    logic [5:0]  res_sqn_q;
    logic        res_exc_q;

    // Handshake decode
    logic        mem_ack;
    logic        accept;
    logic        no_mem;
    logic        issue;
    logic        rv_hit;
    logic [1:0]  rv_idx;
    logic [1:0]  scan_idx;
    logic        rv_fire;
    logic        byp;
    logic        pop;
    logic [31:0] res_src;

    assign OUT_memReq   = (state_q == S_WAIT_ACK);
    assign OUT_memWe    = req_we_q;
    assign OUT_memAddr  = req_addr_q;
    assign OUT_memWdata = req_wdata_q;
    assign OUT_memWmask = req_wmask_q;

    assign mem_ack   = OUT_memReq && IN_memAck;
    assign OUT_stall = (count_q == 3'd4) || (OUT_memReq && !IN_memAck);
    assign accept    = IN_valid && !OUT_stall;
    // Faulted or malformed uops never touch memory; they complete at push time
    assign no_mem    = IN_exception || (IN_size == 2'd3);
    assign issue     = accept && !no_mem;

    assign OUT_resValid     = res_valid_q;
    assign OUT_resData      = res_data_q;
    assign OUT_resTagDst    = res_tag_q;
    assign OUT_resNmDst     = res_nm_q;
    assign OUT_resSqN       = res_sqn_q;
    assign OUT_resException = res_exc_q;

    // Align and extend the addressed bytes of a full memory word
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] size, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            2'd0:    extract = sext ? {{24{b[7]}}, b} : {24'd0, b};
            2'd1:    extract = sext ? {{16{h[15]}}, h} : {16'd0, h};
            default: extract = w;
        endcase
    endfunction

    // Issue FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue FSM next state: a new memory uop can only arrive in WAIT_ACK on the ack edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (mem_ack && !issue) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Find the oldest acked load still waiting for its read data
    always_comb begin
        rv_hit   = 1'b0;
        rv_idx   = head_q;
        scan_idx = head_q;
        for (int i = 0; i < 4; i++) begin
            scan_idx = head_q + 2'(i);
            if (!rv_hit && (3'(i) < count_q) && ent_load_q[scan_idx] &&
                ent_acked_q[scan_idx] && !ent_done_q[scan_idx]) begin
                rv_hit = 1'b1;
                rv_idx = scan_idx;
            end
        end
    end

    assign rv_fire = IN_memRvalid && rv_hit;

`ifdef MEM_RDATA_BYPASS_EN
    assign byp = rv_fire && (rv_idx == head_q);
`else
    assign byp = 1'b0;
`endif

    // Pop control, pointer/count next state and result formatting
    always_comb begin
        pop     = (count_q != 3'd0) && (ent_done_q[head_q] || byp);
        count_d = count_q + {2'd0, accept} - {2'd0, pop};
        head_d  = head_q + {1'b0, pop};
        tail_d  = tail_q + {1'b0, accept};
        res_src = byp ? IN_memRdata : ent_data_q[head_q];
        res_data_d = 32'd0;
        if (ent_load_q[head_q] && !ent_exc_q[head_q]) begin
            res_data_d = extract(res_src, ent_off_q[head_q], ent_size_q[head_q], ent_sext_q[head_q]);
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 3'd0;
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Request register: loaded on every memory-bound accept, held until the ack edge
    always_ff @(posedge clk) begin
        if (!rst && issue) begin
            req_addr_q  <= IN_addr[31:2];
            req_we_q    <= !IN_isLoad;
            req_wdata_q <= IN_wdata;
            req_wmask_q <= IN_wmask;
            req_idx_q   <= tail_q;
        end
    end

    // Entry updates: push at tail, ack at issue pointer, read data at oldest waiting load
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                ent_load_q[tail_q]  <= IN_isLoad;
                ent_sext_q[tail_q]  <= IN_signExt;
                ent_exc_q[tail_q]   <= no_mem;
                ent_acked_q[tail_q] <= 1'b0;
                ent_done_q[tail_q]  <= no_mem;
                ent_off_q[tail_q]   <= IN_addr[1:0];
                ent_size_q[tail_q]  <= IN_size;
                ent_tag_q[tail_q]   <= IN_tagDst;
                ent_nm_q[tail_q]    <= IN_nmDst;
                ent_sqn_q[tail_q]   <= IN_sqN;
            end
            if (mem_ack) begin
                ent_acked_q[req_idx_q] <= 1'b1;
                if (req_we_q) begin
                    ent_done_q[req_idx_q] <= 1'b1;
                end
            end
            if (rv_fire && !byp) begin
                ent_data_q[rv_idx] <= IN_memRdata;
                ent_done_q[rv_idx] <= 1'b1;
            end
        end
    end

    // Result register: one valid pulse per popped entry
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= pop;
            if (pop) begin
                res_data_q <= res_data_d;
                res_tag_q  <= ent_tag_q[head_q];
                res_nm_q   <= ent_nm_q[head_q];
                res_sqn_q  <= ent_sqn_q[head_q];
                res_exc_q  <= ent_exc_q[head_q];
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge; reset rst, synchronous, active-high.
REQ-002 rst  in  1  synchronous active-high reset.
REQ-003 IN_valid  in  1  memory uop offered this cycle.
REQ-004 IN_isLoad in 1 (1 load, 0 store); IN_addr in 32 physical byte address; IN_size in 2 (0 byte, 1 half, 2 word); IN_signExt in 1 (loads only).
REQ-005 IN_wdata in 32 store data, pre-shifted to byte lanes; IN_wmask in 4 store byte enables.
REQ-006 IN_exception in 1 upstream fault; IN_tagDst in 6, IN_nmDst in 5, IN_sqN in 6 result tags.
REQ-007 OUT_stall  out  1  uop not accepted this cycle.
REQ-008 OUT_memReq out 1; OUT_memWe out 1; OUT_memAddr out 30 (word address = addr[31:2]); OUT_memWdata out 32; OUT_memWmask out 4.
REQ-009 IN_memAck in 1 request taken when OUT_memReq and IN_memAck are high at a rising edge; IN_memRvalid in 1; IN_memRdata in 32 full aligned word.
REQ-010 OUT_resValid out 1; OUT_resData out 32; OUT_resTagDst out 6; OUT_resNmDst out 5; OUT_resSqN out 6; OUT_resException out 1.

Function
REQ-011 Tracking FIFO SHALL hold 4 entries: isLoad, offset addr[1:0], size, signExt, exception, tags, acked, done, data[31:0].
REQ-012 OUT_stall = (count==4) || (OUT_memReq && !IN_memAck); accept = IN_valid && !OUT_stall.
REQ-013 On accept: push entry; exception=1 or size==3 -> noMem entry, done=1 at push, exception=1, no memory request.
REQ-014 Otherwise the request register SHALL load addr/we/wdata/wmask and drive OUT_memReq=1 from the next cycle, held stable until the ack edge.
REQ-015 Issue FSM: IDLE -> WAIT_ACK on memory-bound accept; WAIT_ACK -> IDLE on ack with no accept; WAIT_ACK stays on ack plus simultaneous accept (back-to-back, no bubble).
REQ-016 On ack, the entry at the issue pointer SHALL set acked=1; stores also set done=1.
REQ-017 IN_memRvalid SHALL fill the oldest entry with isLoad=1, acked=1, done=0 and set done=1; responses are in ack order, at least 1 cycle after ack; rvalid with no such entry is ignored.
REQ-018 Head entry with done=1 SHALL pop, at most one per cycle; results leave strictly in accept order.
REQ-019 Load data: byte = rdata[8*off+:8], half = rdata[16*off[1]+:16], word = rdata; zero- or sign-extended per signExt to 32 bits.
REQ-020 Stores and exceptional entries SHALL produce OUT_resData=0; OUT_resException = entry exception.
REQ-021 Result outputs registered: OUT_resValid high exactly one cycle per popped entry, tags copied from entry.
REQ-022 Latency: rvalid in cycle M -> OUT_resValid in M+2 if the entry is at head; store acked in cycle A at head -> OUT_resValid in A+2; noMem accepted in N at head -> OUT_resValid in N+2.
REQ-023 Push and pop in the same cycle with count==4 SHALL not be permitted (stall holds); with count<4 both occur, count unchanged.
REQ-024 Pointers SHALL wrap modulo 4; count range 0..4.

Reset
REQ-025 rst SHALL clear count, pointers, issue FSM to IDLE, OUT_memReq=0, OUT_resValid=0, OUT_stall reflects empty FIFO (0) the following cycle.
REQ-026 rst mid-transaction SHALL drop an unacked request and discard all entries; later rvalid/ack for discarded requests are ignored until a new request is issued.
REQ-027 Data-path outputs (addr, wdata, resData, tags) are don't-care after reset while their valid is 0.

Configuration
REQ-028 Macro MEM_RDATA_BYPASS_EN defined: rvalid for the head entry SHALL pop it in the same cycle, extracting directly from IN_memRdata, giving OUT_resValid in M+1.
REQ-029 Macro MEM_RDATA_BYPASS_EN undefined: rdata always written to the entry first; latency per REQ-022.

Verification
REQ-030 Load byte addr 0x103, signExt=1, rdata 0x80FF_1234 -> memAddr 0x40, OUT_resData 0xFFFF_FF80, resValid M+2 (M+1 with bypass).
REQ-031 Load half addr 0x202, signExt=0, rdata 0xBEEF_0001 -> OUT_resData 0x0000_BEEF.
REQ-032 IN_exception=1 store, tag 5 -> no OUT_memReq, OUT_resException=1, resData 0, resValid 2 cycles after accept.
REQ-033 5 loads back-to-back, IN_memAck held 0 -> 1st accepted, OUT_stall=1 from 2nd; ack and rvalid released -> 5 results in order.
REQ-034 Store then load, load rvalid 1 cycle after store ack -> store result precedes load result, both once.
REQ-035 rst asserted while OUT_memReq=1 unacked, 2 entries pending -> next cycle OUT_memReq=0, no OUT_resValid, stray rvalid ignored.
